// File: rtl/accum_warp_looper_index_stage.sv
// Expands one loop command into a stream of warps, one per point of a VDIM-deep
// accumulation-offset odometer; the innermost dimension (VDIM-1) advances fastest.
module accum_warp_looper_index_stage #(
    parameter int N_CFG = 4,
    parameter int WBW   = 8,
    parameter int VDIM  = 2,
    localparam int NCFG_BW = $clog2(N_CFG + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          src_rdy,
    output logic                          src_ack,
    input  logic [NCFG_BW-1:0]            i_id,
    input  logic [VDIM-1:0][WBW-1:0]      i_bofs,
    input  logic [VDIM-1:0][WBW-1:0]      i_abeg,
    input  logic [VDIM-1:0][WBW-1:0]      i_aend,
    input  logic [VDIM-1:0][WBW-1:0]      i_astep,
    input  logic                          i_islast,
    output logic                          dst_rdy,
    input  logic                          dst_ack,
    output logic [NCFG_BW-1:0]            o_id,
    output logic [VDIM-1:0][WBW-1:0]      o_bofs,
    output logic [VDIM-1:0][WBW-1:0]      o_aofs,
    output logic                          o_retire,
    output logic                          o_islast
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                     r_state;
    logic                       r_dst_rdy;
    logic [NCFG_BW-1:0]         r_id;
    logic [VDIM-1:0][WBW-1:0]   r_bofs;
    logic [VDIM-1:0][WBW-1:0]   r_aofs;
    logic [VDIM-1:0][WBW-1:0]   r_abeg;
    logic [VDIM-1:0][WBW-1:0]   r_aend;
    logic [VDIM-1:0][WBW-1:0]   r_astep;
    logic                       r_islast;

    logic [VDIM-1:0][WBW:0]     w_sum;
    logic [VDIM-1:0]            w_wrap;
    logic [VDIM-1:0][WBW-1:0]   w_aofs_next;

    // The extra sum bit keeps an overflowing aofs+step from wrapping back into range.
    for (genvar gi = 0; gi < VDIM; gi++) begin : g_dim
        logic w_en;
        assign w_sum[gi]  = {1'b0, r_aofs[gi]} + {1'b0, r_astep[gi]};
        assign w_wrap[gi] = (w_sum[gi] >= {1'b0, r_aend[gi]});
        if (gi == VDIM - 1) begin : g_inner
            assign w_en = 1'b1;
        end else begin : g_outer
            assign w_en = g_dim[gi+1].w_en & w_wrap[gi+1];
        end
        assign w_aofs_next[gi] = !w_en      ? r_aofs[gi] :
                                 w_wrap[gi] ? r_abeg[gi] : w_sum[gi][WBW-1:0];
    end

    assign src_ack  = (r_state == S_IDLE) & src_rdy;
    assign dst_rdy  = r_dst_rdy;
    assign o_id     = r_id;
    assign o_bofs   = r_bofs;
    assign o_aofs   = r_aofs;
    assign o_retire = &w_wrap;
    assign o_islast = o_retire & r_islast;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_dst_rdy <= 1'b0;
            r_id      <= '0;
            r_bofs    <= '0;
            r_aofs    <= '0;
            r_abeg    <= '0;
            r_aend    <= '0;
            r_astep   <= '0;
            r_islast  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (src_rdy) begin
                        r_id      <= i_id;
                        r_bofs    <= i_bofs;
                        r_aofs    <= i_abeg;
                        r_abeg    <= i_abeg;
                        r_aend    <= i_aend;
                        r_astep   <= i_astep;
                        r_islast  <= i_islast;
                        r_dst_rdy <= 1'b1;
                        r_state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (dst_ack) begin
                        if (o_retire) begin
                            r_dst_rdy <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_aofs <= w_aofs_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_warp_looper_index_stage.sv
// Directed table-driven bench for the warp index looper, plus hand-written
// back-to-back and mid-command reset sequences.
module tb_accum_warp_looper_index_stage;
    localparam int N_CFG   = 4;
    localparam int WBW     = 8;
    localparam int VDIM    = 2;
    localparam int NCFG_BW = $clog2(N_CFG + 1);

    logic                     i_clk = 1'b0;
    logic                     i_rst;
    logic                     src_rdy, src_ack;
    logic [NCFG_BW-1:0]       i_id;
    logic [VDIM-1:0][WBW-1:0] i_bofs, i_abeg, i_aend, i_astep;
    logic                     i_islast;
    logic                     dst_rdy, dst_ack;
    logic [NCFG_BW-1:0]       o_id;
    logic [VDIM-1:0][WBW-1:0] o_bofs, o_aofs;
    logic                     o_retire, o_islast;

    accum_warp_looper_index_stage #(.N_CFG(N_CFG), .WBW(WBW), .VDIM(VDIM)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .src_rdy(src_rdy), .src_ack(src_ack),
        .i_id(i_id), .i_bofs(i_bofs), .i_abeg(i_abeg), .i_aend(i_aend),
        .i_astep(i_astep), .i_islast(i_islast),
        .dst_rdy(dst_rdy), .dst_ack(dst_ack),
        .o_id(o_id), .o_bofs(o_bofs), .o_aofs(o_aofs),
        .o_retire(o_retire), .o_islast(o_islast)
    );

    always #5 i_clk = ~i_clk;

    // One table row: command fields (dim 0 = outer, dim 1 = inner), ack mode, expected warps.
    typedef struct packed {
        logic [7:0]           ab0, ab1, ae0, ae1, as0, as1;
        logic                 isl;
        logic                 toggle;
        logic [3:0]           nw;
        logic [0:7][15:0]     exp_w;   // each entry {outer, inner}
    } vec_t;

    vec_t        tbl [6];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] got_w [$];
    logic        got_ret [$];
    logic        got_isl [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cur_aofs();
        return {o_aofs[0], o_aofs[1]};
    endfunction

    task automatic drive_cmd(input logic [2:0] id, input logic [7:0] ab0, ab1, ae0, ae1,
                             as0, as1, input logic isl, input logic [15:0] bofs);
        i_id     = id;
        i_abeg   = {ab1, ab0};
        i_aend   = {ae1, ae0};
        i_astep  = {as1, as0};
        i_islast = isl;
        i_bofs   = {bofs[7:0], bofs[15:8]};
        src_rdy  = 1'b1;
    endtask

    // Called at a negedge with src_rdy high; returns at the negedge after the transfer.
    task automatic accept(input string tag);
        int n = 0;
        #1;
        while (!src_ack && n < 20) begin
            @(negedge i_clk); #1; n++;
        end
        check({tag, "_accept"}, src_ack, 1'b1);
        @(posedge i_clk);
        @(negedge i_clk);
        src_rdy = 1'b0;
        #1;
        check({tag, "_latency"}, dst_rdy, 1'b1);
    endtask

    // Consumes warps until a retire is acked; toggle mode holds each warp one idle cycle first.
    task automatic collect(input string tag, input bit toggle, input logic [2:0] id,
                           input logic [15:0] bofs);
        int   budget = 0;
        bit   done = 0;
        logic [17:0] held;
        got_w.delete(); got_ret.delete(); got_isl.delete();
        while (!done && budget < 64) begin
            budget++;
            if (!dst_rdy) begin
                check({tag, "_rdy_lost"}, dst_rdy, 1'b1);
                break;
            end
            check({tag, "_id"}, o_id, id);
            check({tag, "_bofs"}, {o_bofs[0], o_bofs[1]}, bofs);
            if (toggle) begin
                held = {cur_aofs(), o_retire, o_islast};
                dst_ack = 1'b0;
                @(negedge i_clk); #1;
                check({tag, "_hold"}, {dst_rdy, cur_aofs(), o_retire, o_islast}, {1'b1, held});
            end
            got_w.push_back(cur_aofs());
            got_ret.push_back(o_retire);
            got_isl.push_back(o_islast);
            if (o_retire) done = 1;
            dst_ack = 1'b1;
            @(negedge i_clk); #1;
        end
        dst_ack = 1'b0;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_rdy_drop"}, dst_rdy, 1'b0);
    endtask

    task automatic verify(input string tag, input vec_t v);
        int n = int'(v.nw);
        check({tag, "_count"}, got_w.size(), n);
        for (int i = 0; i < n && i < got_w.size(); i++) begin
            check($sformatf("%s_aofs%0d", tag, i), got_w[i], v.exp_w[i]);
            check($sformatf("%s_retire%0d", tag, i), got_ret[i], (i == n - 1));
            check($sformatf("%s_islast%0d", tag, i), got_isl[i], v.isl && (i == n - 1));
        end
    endtask

    initial begin
        tbl[0] = '{ab0:8'd0, ab1:8'd0, ae0:8'd2, ae1:8'd3, as0:8'd1, as1:8'd1, isl:1'b0, toggle:1'b0,
                   nw:4'd6, exp_w:{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0101, 16'h0102, 16'h0, 16'h0}};
        tbl[1] = '{ab0:8'd0, ab1:8'd0, ae0:8'd2, ae1:8'd3, as0:8'd1, as1:8'd1, isl:1'b1, toggle:1'b1,
                   nw:4'd6, exp_w:{16'h0000, 16'h0001, 16'h0002, 16'h0100, 16'h0101, 16'h0102, 16'h0, 16'h0}};
        tbl[2] = '{ab0:8'd0, ab1:8'd5, ae0:8'd1, ae1:8'd12, as0:8'd1, as1:8'd4, isl:1'b1, toggle:1'b0,
                   nw:4'd2, exp_w:{16'h0005, 16'h0009, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[3] = '{ab0:8'd0, ab1:8'd250, ae0:8'd1, ae1:8'd255, as0:8'd1, as1:8'd4, isl:1'b0, toggle:1'b0,
                   nw:4'd2, exp_w:{16'h00FA, 16'h00FE, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[4] = '{ab0:8'd3, ab1:8'd3, ae0:8'd3, ae1:8'd3, as0:8'd1, as1:8'd1, isl:1'b1, toggle:1'b0,
                   nw:4'd1, exp_w:{16'h0303, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}};
        tbl[5] = '{ab0:8'd1, ab1:8'd0, ae0:8'd6, ae1:8'd2, as0:8'd2, as1:8'd1, isl:1'b0, toggle:1'b1,
                   nw:4'd6, exp_w:{16'h0100, 16'h0101, 16'h0300, 16'h0301, 16'h0500, 16'h0501, 16'h0, 16'h0}};

        i_rst = 1'b0; src_rdy = 1'b0; dst_ack = 1'b0;
        i_id = '0; i_bofs = '0; i_abeg = '0; i_aend = '0; i_astep = '0; i_islast = 1'b0;
        #1;
        check("reset_dst_rdy", dst_rdy, 1'b0);
        check("reset_outs", {o_id, o_bofs, o_aofs, o_islast}, '0);
        check("reset_src_ack", src_ack, 1'b0);
        @(negedge i_clk); @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);

        for (int k = 0; k < 6; k++) begin
            string tag = $sformatf("vec%0d", k);
            logic [15:0] bofs = {8'hA0 + 8'(k), 8'hB0 + 8'(k)};
            logic [2:0]  id   = 3'(k % 5);
            drive_cmd(id, tbl[k].ab0, tbl[k].ab1, tbl[k].ae0, tbl[k].ae1,
                      tbl[k].as0, tbl[k].as1, tbl[k].isl, bofs);
            accept(tag);
            collect(tag, tbl[k].toggle, id, bofs);
            verify(tag, tbl[k]);
            @(negedge i_clk);
        end

        // Back-to-back: src_rdy stays high across the first command.
        drive_cmd(3'd2, 8'd0, 8'd5, 8'd1, 8'd12, 8'd1, 8'd4, 1'b0, 16'h1122);
        #1;
        check("b2b_first_ack", src_ack, 1'b1);
        @(posedge i_clk); @(negedge i_clk);
        drive_cmd(3'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd1, 8'd1, 1'b1, 16'h3344);
        dst_ack = 1'b1;
        #1;
        check("b2b_busy_noack0", src_ack, 1'b0);
        check("b2b_w0", {dst_rdy, cur_aofs(), o_retire}, {1'b1, 16'h0005, 1'b0});
        @(negedge i_clk); #1;
        check("b2b_busy_noack1", src_ack, 1'b0);
        check("b2b_w1", {dst_rdy, cur_aofs(), o_retire}, {1'b1, 16'h0009, 1'b1});
        @(negedge i_clk); #1;
        check("b2b_bubble_rdy", dst_rdy, 1'b0);
        check("b2b_second_ack", src_ack, 1'b1);
        @(posedge i_clk); @(negedge i_clk);
        src_rdy = 1'b0;
        #1;
        check("b2b_second_warp", {dst_rdy, o_id, cur_aofs(), o_retire, o_islast},
              {1'b1, 3'd3, 16'h0303, 1'b1, 1'b1});
        @(negedge i_clk); #1;
        dst_ack = 1'b0;
        check("b2b_second_done", dst_rdy, 1'b0);

        // Reset in the middle of a command.
        @(negedge i_clk);
        drive_cmd(3'd4, 8'd0, 8'd0, 8'd2, 8'd3, 8'd1, 8'd1, 1'b1, 16'h5566);
        accept("rst");
        dst_ack = 1'b1;
        @(negedge i_clk); @(negedge i_clk);
        check("rst_midcmd_aofs", cur_aofs(), 16'h0002);
        i_rst = 1'b0;
        #1;
        check("rst_dst_rdy", dst_rdy, 1'b0);
        check("rst_outs", {o_id, o_bofs, o_aofs, o_islast}, '0);
        @(negedge i_clk);
        i_rst = 1'b1;
        dst_ack = 1'b0;
        @(negedge i_clk); #1;
        check("rst_no_more_warps", dst_rdy, 1'b0);
        drive_cmd(3'd1, 8'd3, 8'd4, 8'd4, 8'd5, 8'd1, 8'd1, 1'b0, 16'h7788);
        accept("post_rst");
        collect("post_rst", 1'b0, 3'd1, 16'h7788);
        check("post_rst_count", got_w.size(), 1);
        if (got_w.size() > 0) check("post_rst_aofs", got_w[0], 16'h0304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/accum_warp_looper_index_stage.md
# accum_warp_looper_index_stage

Upstream neighbour of the accumulate-warp memory-offset stage. Accepts one loop command per handshake: config id, block offset and an accumulation-offset range. Expands the command into a sequence of warps, one per accumulation-offset point in a VDIM-deep nested loop, and emits each warp as `{id, bofs, aofs, retire, islast}` on a rdy/ack output. The memory-offset stage downstream converts these into linear addresses.

## Interface
- N_CFG, TauCfg::N_ICFG, number of config slots; NCFG_BW = $clog2(N_CFG+1)
- WBW, TauCfg::WORK_BW, width of every offset/bound/step
- VDIM, TauCfg::VDIM, loop depth; dimension VDIM-1 is innermost (fastest)
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- src_rdy  in  1  command valid
- src_ack  out  1  command accepted (transfer on rdy&&ack)
- i_id  in  NCFG_BW  config id
- i_bofs  in  WBW x VDIM  block offset, passed through unchanged
- i_abeg  in  WBW x VDIM  accumulation start per dim
- i_aend  in  WBW x VDIM  accumulation end per dim (exclusive)
- i_astep  in  WBW x VDIM  accumulation step per dim (nonzero)
- i_islast  in  1  command is last of its block
- dst_rdy  out  1  warp valid
- dst_ack  in  1  warp consumed; asserted only while dst_rdy=1
- o_id  out  NCFG_BW  latched id
- o_bofs  out  WBW x VDIM  latched block offset
- o_aofs  out  WBW x VDIM  current accumulation offset
- o_retire  out  1  this warp is the last point of the command
- o_islast  out  1  o_retire && latched i_islast

## Operation
- States: IDLE, BUSY. Reset → IDLE.
- IDLE: src_ack = src_rdy (combinational). On accept, latch id/bofs/abeg/aend/astep/islast; o_aofs ← i_abeg; dst_rdy ← 1; go BUSY.
- BUSY: src_ack = 0. On dst_ack:
  - Not retire: advance odometer. The innermost dim d = VDIM-1 steps first.
  - Step rule per dim d: nxt = aofs[d] + astep[d] computed at WBW+1 bits. If nxt ≥ aend[d] (unsigned, WBW+1 compare), aofs[d] ← abeg[d] and carry to d-1; else aofs[d] ← nxt[WBW-1:0] and stop.
  - Retire warp: dst_rdy ← 0; go IDLE.
- o_retire is combinational from the state registers. It is 1 iff, for every dim, aofs[d]+astep[d] ≥ aend[d] (WBW+1 bits).
- The WBW+1 compare guarantees that wrap-around overflow of aofs+step never re-enters the range.
- Empty dim (aend ≤ abeg) executes once at abeg (do-while semantics). An all-empty command yields exactly one warp with o_retire=1.
- Warp count = Π ceil((aend[d]-abeg[d])/astep[d]), with each empty-dim factor taken as 1.
- o_id, o_bofs and o_islast's latched part are stable for the whole command.

## Timing
- Reset (i_rst=0, async): state IDLE, dst_rdy=0, o_id=0, o_bofs=0, o_aofs=0, latched islast=0, all latched bounds/steps=0. Consequently o_retire=1 and o_islast=0, but these are don't-care while dst_rdy=0.
- Reset mid-command discards the command with no further warps. The first command after reset is accepted normally.
- Latency: command accepted at cycle t → first warp has dst_rdy=1 at t+1.
- Throughput: one warp per cycle while dst_ack is held high. One bubble cycle per command: a retire acked at t allows src_ack at t+1 at the earliest.
- Backpressure: with dst_ack low, all outputs hold indefinitely.
- src_ack is never asserted while BUSY, even if src_rdy is high.

## Test plan
- VDIM=2, abeg={0,0}, aend={2,3}, astep={1,1}, dst_ack always 1 → 6 consecutive warps: aofs (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); o_retire only on (1,2); dst_rdy drops the next cycle.
- Same command, i_islast=1, dst_ack toggling 1/0 → same 6 warps in order with no duplicates; o_islast=1 only on (1,2); outputs stable while ack=0.
- abeg={0,5}, aend={1,12}, astep={1,4} → warps (0,5),(0,9); retire on (0,9).
- Overflow: WBW=8, abeg[inner]=250, aend=255, astep=4 → warps 250,254 then retire; no wrap to 2.
- Empty range aend=abeg={3,3} → exactly one warp aofs (3,3) with o_retire=1.
- Back-to-back commands with src_rdy held high → second src_ack exactly one cycle after first retire ack; assert i_rst low mid-command → dst_rdy=0 and all outputs zero immediately; next command starts at its abeg.
